// File: rtl/bcd_pkg.sv
// Shared constants, state encoding and sizing helper for the sequential binary-to-BCD converter.
package bcd_pkg;

  localparam int unsigned BCD_DIGIT_W     = 4;
  localparam logic [3:0]  BCD_ADD3_THRESH = 4'd5;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } bcd_state_e;

  // Decimal digits needed for 2^bin_w - 1, i.e. floor(bin_w * log10(2)) + 1.
  // 2^bin_w is never a power of ten, so the fixed-point log10(2) is exact enough.
  function automatic int unsigned bcd_min_digits(input int unsigned bin_w);
    return (bin_w * 30103) / 100000 + 1;
  endfunction

endpackage

// File: rtl/bcd_dabble_digit.sv
// One double-dabble digit slice: add 3 when the digit is 5 or more, then shift left by one.
module bcd_dabble_digit
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  input  logic                   shift_i,
  output logic [BCD_DIGIT_W-1:0] digit_o,
  output logic                   shift_o
);

  logic [BCD_DIGIT_W-1:0] adj;

  always_comb begin
    adj = (digit_i >= BCD_ADD3_THRESH) ? digit_i + 4'd3 : digit_i;
  end

  assign digit_o = {adj[BCD_DIGIT_W-2:0], shift_i};
  assign shift_o = adj[BCD_DIGIT_W-1];

endmodule

// File: rtl/bcd_seq_converter.sv
// Sequential binary-to-BCD converter: one bit per clock with valid/ready on both sides,
// plus overflow and leading-zero blanking for a display driver.
module bcd_seq_converter
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [BIN_W-1:0]              in_value,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BCD_DIGIT_W*DIGITS-1:0] out_bcd,
  output logic                          overflow,
  output logic [DIGITS-1:0]             blank
);

  localparam int unsigned    BcdW        = BCD_DIGIT_W * DIGITS;
  localparam int unsigned    CntW        = $clog2(BIN_W + 1);
  localparam logic [CntW-1:0] LastCnt    = CntW'(BIN_W - 1);
  // With enough digits the top slice can never carry out, so overflow is constant zero.
  localparam bit             CanOverflow = DIGITS < bcd_min_digits(BIN_W);

  bcd_state_e        state_q, state_d;
  logic [BIN_W-1:0]  bin_q, bin_d;
  logic [BcdW-1:0]   bcd_q, bcd_d;
  logic              carry_q, carry_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [BcdW-1:0]   out_bcd_q, out_bcd_d;
  logic              ovf_q, ovf_d;

  logic [BcdW-1:0]   bcd_step;
  logic [DIGITS:0]   chain;
  logic              carry_step;

  assign chain[0] = bin_q[BIN_W-1];

  for (genvar g = 0; g < DIGITS; g++) begin : gen_digit
    bcd_dabble_digit u_digit (
      .digit_i (bcd_q[BCD_DIGIT_W*g +: BCD_DIGIT_W]),
      .shift_i (chain[g]),
      .digit_o (bcd_step[BCD_DIGIT_W*g +: BCD_DIGIT_W]),
      .shift_o (chain[g+1])
    );
  end

  assign carry_step = carry_q | chain[DIGITS];

  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    out_bcd_d = out_bcd_q;
    ovf_d     = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          bin_d   = in_value;
          bcd_d   = '0;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        bin_d   = bin_q << 1;
        bcd_d   = bcd_step;
        carry_d = carry_step;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          out_bcd_d = bcd_step;
          ovf_d     = CanOverflow && carry_step;
          state_d   = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      bin_q     <= '0;
      bcd_q     <= '0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      out_bcd_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      carry_q   <= carry_d;
      cnt_q     <= cnt_d;
      out_bcd_q <= out_bcd_d;
      ovf_q     <= ovf_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign out_bcd   = out_bcd_q;
  assign overflow  = ovf_q;

  // blank[i] is set while digit i and every digit above it are zero; digit 0 always shows.
  logic zero_above;
  always_comb begin
    blank      = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above && (out_bcd_q[BCD_DIGIT_W*i +: BCD_DIGIT_W] == '0);
      blank[i]   = zero_above;
    end
  end

endmodule
